// File: rtl/id_control_pipe_pkg.sv
// Shared definitions for the ID-stage control pipeline: opcodes, ALUop
// encodings, control-field widths and bit positions, and the control bundle.
package id_control_pipe_pkg;

    // Opcodes (IR[31:26]) recognised by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUop encodings; 2'b11 is deliberately absent because the ALU decoder
    // downstream treats it as undefined
    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10
    } aluop_e;

    // Field widths
    localparam int EX_W   = 4;
    localparam int MEM_W  = 3;
    localparam int WB_W   = 2;
    localparam int CTRL_W = EX_W + MEM_W + WB_W;

    // EX field: {RegDst, ALUop[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    // MEM field: {Branch, MemRead, MemWrite}
    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;

    // WB field: {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Full control bundle produced by decode; all-zero is a bubble
    typedef struct packed {
        logic [EX_W-1:0]  ex;
        logic [MEM_W-1:0] mem;
        logic [WB_W-1:0]  wb;
    } ctrl_t;

endpackage

// File: rtl/id_control_pipe_ctrl_decode.sv
// Purely combinational main-control decoder: opcode to the nine EX/MEM/WB
// control bits plus a flag saying whether the opcode is one we implement.
module ctrl_decode
    import id_control_pipe_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       legal
);

    // Decode opcode; anything unrecognised yields a bubble with legal low
    always_comb begin
        ctrl  = '0;
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                legal                              = 1'b1;
                ctrl.ex[EX_REGDST]                 = 1'b1;
                ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_RTYPE;
                ctrl.wb[WB_REGWRITE]               = 1'b1;
            end
            OP_LW: begin
                legal                              = 1'b1;
                ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_MEM;
                ctrl.ex[EX_ALUSRC]                 = 1'b1;
                ctrl.mem[MEM_READ]                 = 1'b1;
                ctrl.wb[WB_REGWRITE]               = 1'b1;
                ctrl.wb[WB_MEMTOREG]               = 1'b1;
            end
            OP_SW: begin
                legal                              = 1'b1;
                ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_MEM;
                ctrl.ex[EX_ALUSRC]                 = 1'b1;
                ctrl.mem[MEM_WRITE]                = 1'b1;
            end
            OP_BEQ: begin
                legal                              = 1'b1;
                ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_BRANCH;
                ctrl.mem[MEM_BRANCH]               = 1'b1;
            end
            OP_ADDI: begin
                legal                              = 1'b1;
                ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_MEM;
                ctrl.ex[EX_ALUSRC]                 = 1'b1;
                ctrl.wb[WB_REGWRITE]               = 1'b1;
            end
            default: begin
                ctrl  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_control_pipe.sv
// Control-signal pipeline from ID through WB. Decoded control rides the
// ID/EX, EX/MEM and MEM/WB registers; stall and flush inject bubbles, and
// unknown opcodes are turned into bubbles and counted.
module id_control_pipe
    import id_control_pipe_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [EX_W-1:0]  ex_ctrl,
    output logic [MEM_W-1:0] mem_ctrl,
    output logic [WB_W-1:0]  wb_ctrl,
    output logic             illegal,
    output logic [ERR_W-1:0] err_count
);

    ctrl_t            dec_ctrl;
    logic             dec_legal;
    logic             accept;

    logic [EX_W-1:0]  idex_ex;
    logic [MEM_W-1:0] idex_mem;
    logic [WB_W-1:0]  idex_wb;
    logic [MEM_W-1:0] exmem_mem;
    logic [WB_W-1:0]  exmem_wb;
    logic [WB_W-1:0]  memwb_wb;

    ctrl_decode u_decode (
        .opcode (opcode),
        .ctrl   (dec_ctrl),
        .legal  (dec_legal)
    );

    // Only a real, unstalled, unflushed instruction may enter EX
    assign accept = id_valid & ~stall & ~flush;

    // ID/EX: load decoded control for an accepted legal opcode, else a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ex  <= '0;
            idex_mem <= '0;
            idex_wb  <= '0;
        end else if (accept && dec_legal) begin
            idex_ex  <= dec_ctrl.ex;
            idex_mem <= dec_ctrl.mem;
            idex_wb  <= dec_ctrl.wb;
        end else begin
            idex_ex  <= '0;
            idex_mem <= '0;
            idex_wb  <= '0;
        end
    end

    // EX/MEM: always advances, except a taken branch kills the EX instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_mem <= '0;
            exmem_wb  <= '0;
        end else if (flush) begin
            exmem_mem <= '0;
            exmem_wb  <= '0;
        end else begin
            exmem_mem <= idex_mem;
            exmem_wb  <= idex_wb;
        end
    end

    // MEM/WB: the branch in MEM has already committed its predecessors, so it never stalls or flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_wb <= '0;
        end else begin
            memwb_wb <= exmem_wb;
        end
    end

    // Illegal-opcode pulse and saturating counter, updated on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal   <= 1'b0;
            err_count <= '0;
        end else begin
            illegal <= accept & ~dec_legal;
            if (accept && !dec_legal && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign ex_ctrl  = idex_ex;
    assign mem_ctrl = exmem_mem;
    assign wb_ctrl  = memwb_wb;

endmodule

// File: tb/tb_id_control_pipe.sv
// Directed bench for id_control_pipe: each step drives ID inputs, queues the
// hand-derived outputs expected after the next rising edge, then pops and
// compares them.
module tb_id_control_pipe;

    localparam int ERR_W = 2;

    localparam logic [5:0] RTY = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        string      tag;
        logic [3:0] ex;
        logic [2:0] mem;
        logic [1:0] wb;
        logic       ill;
        logic [1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [5:0]       opcode = '0;
    logic             id_valid = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic [3:0]       ex_ctrl;
    logic [2:0]       mem_ctrl;
    logic [1:0]       wb_ctrl;
    logic             illegal;
    logic [ERR_W-1:0] err_count;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    id_control_pipe #(.ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .id_valid  (id_valid),
        .stall     (stall),
        .flush     (flush),
        .ex_ctrl   (ex_ctrl),
        .mem_ctrl  (mem_ctrl),
        .wb_ctrl   (wb_ctrl),
        .illegal   (illegal),
        .err_count (err_count)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    task automatic compare(input string tag, input string field,
                           input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s.%s observed=%b expected=%b", tag, field, obs, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        compare(e.tag, "ex_ctrl",   {4'b0, ex_ctrl},   {4'b0, e.ex});
        compare(e.tag, "mem_ctrl",  {5'b0, mem_ctrl},  {5'b0, e.mem});
        compare(e.tag, "wb_ctrl",   {6'b0, wb_ctrl},   {6'b0, e.wb});
        compare(e.tag, "illegal",   {7'b0, illegal},   {7'b0, e.ill});
        compare(e.tag, "err_count", {6'b0, err_count}, {6'b0, e.cnt});
    endtask

    task automatic expect_now(input string tag, input logic [3:0] ex, input logic [2:0] mem,
                              input logic [1:0] wb, input logic ill, input logic [1:0] cnt);
        exp_t e;
        e.tag = tag; e.ex = ex; e.mem = mem; e.wb = wb; e.ill = ill; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input string tag, input logic [5:0] op, input logic v,
                                  input logic s, input logic f,
                                  input logic [3:0] ex, input logic [2:0] mem,
                                  input logic [1:0] wb, input logic ill, input logic [1:0] cnt);
        opcode   = op;
        id_valid = v;
        stall    = s;
        flush    = f;
        expect_now(tag, ex, mem, wb, ill, cnt);
        @(posedge clk);
        #1;
        check_output();
    endtask

    // Directed sequence of steps
    initial begin
        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        expect_now("reset_async", 4'b0000, 3'b000, 2'b00, 1'b0, 2'd0);
        check_output();
        @(negedge clk);
        rst_n = 1'b1;

        // lw through all stages, no extra latency after reset
        apply_stimulus("lw_ex",   LW,  1, 0, 0, 4'b0001, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("lw_mem",  RTY, 0, 0, 0, 4'b0000, 3'b010, 2'b00, 0, 2'd0);
        apply_stimulus("lw_wb",   RTY, 0, 0, 0, 4'b0000, 3'b000, 2'b11, 0, 2'd0);
        apply_stimulus("lw_done", RTY, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd0);

        // R-type, then sw stalled one cycle
        apply_stimulus("r_ex",      RTY, 1, 0, 0, 4'b1100, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("sw_stall",  SW,  1, 1, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("sw_ex",     SW,  1, 0, 0, 4'b0001, 3'b000, 2'b10, 0, 2'd0);
        apply_stimulus("sw_mem",    RTY, 0, 0, 0, 4'b0000, 3'b001, 2'b00, 0, 2'd0);
        apply_stimulus("sw_wb",     RTY, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd0);

        // lw in MEM, beq in EX, addi in ID, flush
        apply_stimulus("fl_lw",     LW,  1, 0, 0, 4'b0001, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("fl_beq",    BEQ, 1, 0, 0, 4'b0010, 3'b010, 2'b00, 0, 2'd0);
        apply_stimulus("fl_flush",  ADI, 1, 0, 1, 4'b0000, 3'b000, 2'b11, 0, 2'd0);
        apply_stimulus("fl_after",  RTY, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd0);

        // flush beats stall: R-type in EX is killed, its RegWrite never reaches WB
        apply_stimulus("fs_r",      RTY, 1, 0, 0, 4'b1100, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("fs_both",   ADI, 1, 1, 1, 4'b0000, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("fs_wb",     RTY, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd0);

        // Unknown opcode that must not count
        apply_stimulus("bad_inval", BAD, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("bad_stall", BAD, 1, 1, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("bad_flush", BAD, 1, 0, 1, 4'b0000, 3'b000, 2'b00, 0, 2'd0);

        // Five illegal opcodes, counter saturates at 3
        apply_stimulus("bad1", BAD, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 1, 2'd1);
        apply_stimulus("bad2", BAD, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 1, 2'd2);
        apply_stimulus("bad3", BAD, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 1, 2'd3);
        apply_stimulus("bad4", BAD, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 1, 2'd3);
        apply_stimulus("bad5", BAD, 1, 0, 0, 4'b0000, 3'b000, 2'b00, 1, 2'd3);
        apply_stimulus("bad_end", RTY, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd3);

        // Fill every stage, then reset asynchronously mid-cycle
        apply_stimulus("rs_lw",  LW,  1, 0, 0, 4'b0001, 3'b000, 2'b00, 0, 2'd3);
        apply_stimulus("rs_sw",  SW,  1, 0, 0, 4'b0001, 3'b010, 2'b00, 0, 2'd3);
        apply_stimulus("rs_beq", BEQ, 1, 0, 0, 4'b0010, 3'b001, 2'b11, 0, 2'd3);
        #1 rst_n = 1'b0;
        #1;
        expect_now("reset_mid", 4'b0000, 3'b000, 2'b00, 1'b0, 2'd0);
        check_output();
        opcode   = RTY;
        id_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Stream resumes with normal timing and no stale control
        apply_stimulus("post_addi", ADI, 1, 0, 0, 4'b0001, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("post_mem",  RTY, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd0);
        apply_stimulus("post_wb",   RTY, 0, 0, 0, 4'b0000, 3'b000, 2'b10, 0, 2'd0);
        apply_stimulus("post_end",  RTY, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
